// File: rtl/data_memory_ctrl.sv
// Single-port byte-addressable data memory with a valid/ready request/response handshake.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               fault_q, fault_d;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept_c;
  logic               oor_c;
  logic               misalign_c;
  logic               fault_c;
  logic [IDX_W-1:0]   idx_c;
  logic [1:0]         lane_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_al_c;
  logic [31:0]        word_rd_c;
  logic [31:0]        wr_word_c;
  logic [31:0]        load_val_c;
  logic [7:0]         byte_rd_c;
  logic [15:0]        half_rd_c;

  assign req_ready = (state_q == IDLE) || rsp_ready;
  assign accept_c  = req_valid && req_ready && !RST;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  assign idx_c     = req_addr[IDX_W+1:2];
  assign oor_c     = |(req_addr >> (IDX_W + 2));
  assign word_rd_c = mem[idx_c];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign fault_c = (req_size == 2'b11) || oor_c || misalign_c;

  // Lane selection forces natural alignment; trapping mode has already faulted misaligned cases.
  always_comb begin
    lane_c     = req_addr[1:0];
    be_c       = 4'hF;
    wdata_al_c = req_wdata;
    case (req_size)
      2'b00: begin
        be_c       = 4'b0001 << req_addr[1:0];
        wdata_al_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_c     = {req_addr[1], 1'b0};
        be_c       = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al_c = {2{req_wdata[15:0]}};
      end
      default: lane_c = 2'b00;
    endcase
  end

  // Merge store data into the current word under byte enables.
  always_comb begin
    wr_word_c = word_rd_c;
    for (int b = 0; b < 4; b++) begin
      if (be_c[b]) wr_word_c[8*b +: 8] = wdata_al_c[8*b +: 8];
    end
  end

  // Load lane extraction and extension.
  always_comb begin
    byte_rd_c  = word_rd_c[{lane_c, 3'b000} +: 8];
    half_rd_c  = lane_c[1] ? word_rd_c[31:16] : word_rd_c[15:0];
    load_val_c = word_rd_c;
    case (req_size)
      2'b00:   load_val_c = req_unsigned ? {24'd0, byte_rd_c} : {{24{byte_rd_c[7]}}, byte_rd_c};
      2'b01:   load_val_c = req_unsigned ? {16'd0, half_rd_c} : {{16{half_rd_c[15]}}, half_rd_c};
      default: load_val_c = word_rd_c;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    if (accept_c) begin
      state_d = RESP;
      fault_d = fault_c;
      rdata_d = (fault_c || req_write) ? 32'd0 : load_val_c;
    end else if ((state_q == RESP) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Memory array is never reset; stores commit at the acceptance edge.
  always_ff @(posedge CLK) begin
    if (accept_c && req_write && !fault_c) mem[idx_c] <= wr_word_c;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words; must be a power of two, at least 4.
REQ-002 Parameter ADDR_W, default 32: byte-address width; must satisfy ADDR_W >= log2(DEPTH_WORDS)+2.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for word loads and for stores.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned (bits 7:0 for a byte, 15:0 for a halfword).
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  out  32  load result, extended per REQ-009; 0 for stores and faults.
REQ-015 rsp_fault  out  1  the access was rejected.

Function
REQ-016 Two states: IDLE (no response held) and RESP (rsp_valid=1).
- IDLE -> RESP on request acceptance.
- RESP -> IDLE on rsp_ready without a new acceptance.
- RESP -> RESP on rsp_ready together with a new acceptance.
REQ-017 req_ready SHALL equal (state==IDLE) || rsp_ready, combinationally, so back-to-back accepted requests sustain one access per cycle.
REQ-018 Latency: a request accepted at edge T SHALL present its response from edge T onward, i.e. in the cycle after acceptance; the response holds stable until consumed.
REQ-019 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; byte lane = req_addr[1:0].
REQ-020 Fault conditions:
- req_size==11.
- Address bits above the word index are non-zero (out of range).
- The alignment rule of REQ-031.
REQ-021 Accepted store without fault: memory is updated at the acceptance edge using byte enables.
- Byte: lane addr[1:0] gets wdata[7:0].
- Halfword: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
- Word: all lanes get wdata.
- Other lanes are unchanged.
REQ-022 Accepted load without fault: the selected lane(s) are extracted, extended per req_unsigned, and registered into rsp_rdata.
REQ-023 A faulted access SHALL NOT modify memory; its response carries rsp_fault=1 and rsp_rdata=0.
REQ-024 A load accepted in the cycle after a store to the same word SHALL return the post-store contents.
REQ-025 Responses SHALL be returned in acceptance order; only one response is held at a time.
REQ-026 req_valid asserted while req_ready=0 has no effect; the requester holds its request stable until accepted.
REQ-027 Memory contents are not initialised; loads from never-written words return X in simulation.

Reset
REQ-028 While RST=1 at a clock edge, the following are forced: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_fault=0. No request is accepted in that cycle.
REQ-029 Reset during RESP discards the pending response. A store committed before reset remains in memory.
REQ-030 Reset SHALL NOT clear memory contents.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN.
- When defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=00, faults per REQ-023.
- When undefined: misaligned addresses are silently aligned by forcing addr[0]=0 (halfword) or addr[1:0]=00 (word), and never fault for alignment.

Verification
REQ-032 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_valid one cycle after acceptance, rsp_rdata=0xDEADBEEF, rsp_fault=0.
REQ-033 Store byte 0x80 at 0x11, then signed byte load at 0x11 -> 0xFFFFFF80. Unsigned byte load at 0x11 -> 0x00000080. Word load at 0x10 -> 0xDEAD80EF.
REQ-034 With rsp_ready=0 after a load, a second request -> req_ready=0 and rsp_rdata holds. Raise rsp_ready -> second request accepted the same cycle, and its response follows in the next cycle.
REQ-035 Word load at byte address 4*DEPTH_WORDS, or req_size=11 -> rsp_fault=1, rsp_rdata=0. A store under the same conditions leaves memory unchanged when checked by readback.
REQ-036 Word store 0x12345678 to 0x22:
- With DMEM_MISALIGN_TRAP_EN: fault, and 0x20 is unchanged.
- Without it: no fault, and a word load at 0x20 returns 0x12345678.
REQ-037 Assert RST while rsp_valid=1 -> rsp_valid=0 next cycle. Stores accepted before reset are still readable afterwards.
